// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions for the HI/LO multiply controller:
// operand width, EX opcode encodings and the controller FSM states.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpMthi  = 3'd3,
    OpMtlo  = 3'd4,
    OpMfhi  = 3'd5,
    OpMflo  = 3'd6
  } ex_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } hilo_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Multiplier handshake between the HI/LO controller (master) and the
// falling-edge multiplier (slave).
interface hilo_ctrl_if;

  logic                           mul_start;
  logic                           mul_signed;
  logic [cpu_pkg::DATA_W-1:0]     mul_a;
  logic [cpu_pkg::DATA_W-1:0]     mul_b;
  logic                           mul_enable;
  logic                           mul_annul;
  logic [2*cpu_pkg::DATA_W-1:0]   mul_result;
  logic                           mul_ready;

  modport master (
    output mul_start,
    output mul_signed,
    output mul_a,
    output mul_b,
    output mul_enable,
    output mul_annul,
    input  mul_result,
    input  mul_ready
  );

  modport slave (
    input  mul_start,
    input  mul_signed,
    input  mul_a,
    input  mul_b,
    input  mul_enable,
    input  mul_annul,
    output mul_result,
    output mul_ready
  );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair: a 64-bit product commit port plus
// independent HI and LO writes for MTHI/MTLO.
module hilo_regs
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                commit,
  input  logic [2*DATA_W-1:0] commit_data,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // The controller never raises commit together with hi_we/lo_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= commit_data[2*DATA_W-1:DATA_W];
      lo_q <= commit_data[DATA_W-1:0];
    end else begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// Multiply issue and HI/LO commit controller: issues MULT/MULTU to the
// multiplier, stalls EX until the product returns, then commits it to HI/LO.
module hilo_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic              flush,
  input  logic              mem_stall,
  hilo_ctrl_if.master       mul,
  output logic              stall_req,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  hilo_state_e         state_q, state_d;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic                op_signed_q;
  logic [2*DATA_W-1:0] res_q;
  logic                busy_first_q;

  logic accept;
  logic res_capture;
  logic commit;
  logic hi_we;
  logic lo_we;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    res_capture = 1'b0;
    commit      = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    stall_req   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_valid && !flush && is_mul_op(ex_op)) begin
          accept    = 1'b1;
          stall_req = 1'b1;
          state_d   = StBusy;
        end else if (ex_valid && !flush && !mem_stall) begin
          hi_we = (ex_op == OpMthi);
          lo_we = (ex_op == OpMtlo);
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          stall_req = 1'b1;
          // Ready seen at the first BUSY edge belongs to the previous product.
          if (mul.mul_ready && !busy_first_q) begin
            res_capture = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        if (flush) begin
          state_d = StIdle;
        end else if (!mem_stall) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_first_q <= accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_signed_q <= 1'b0;
    end else if (accept) begin
      op_a_q      <= ex_rs;
      op_b_q      <= ex_rt;
      op_signed_q <= (ex_op == OpMult);
    end
  end

  // A flushed product is dropped so it can never reach HI/LO later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (flush) begin
      res_q <= '0;
    end else if (res_capture) begin
      res_q <= mul.mul_result;
    end
  end

  hilo_regs u_hilo_regs (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .commit_data (res_q),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (ex_rs),
    .hi          (hi),
    .lo          (lo)
  );

  assign mul.mul_start  = (state_q == StBusy);
  assign mul.mul_signed = op_signed_q;
  assign mul.mul_a      = op_a_q;
  assign mul.mul_b      = op_b_q;
  assign mul.mul_enable = ~mem_stall;
  assign mul.mul_annul  = flush;

  assign mf_data = (ex_op == OpMfhi) ? hi : lo;

endmodule
